fifo_sp_ram_ctrl: RTL and testbench

// - Synchronous FIFO controller that stores its data in an external RAM (separate write/read address ports).
// - Generates RAM write strobe, write/read addresses and write data.
// - Returns popped data with a valid pulse, and provides empty/full status.
// - Sits between a producer/consumer pair and a sp_ram instance of matching width and depth.

---
 rtl/fifo_sp_ram_ctrl_if.sv | 23 ++
 rtl/fifo_sp_ram_ctrl.sv | 123 ++++++++++++
 tb/tb_fifo_sp_ram_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_sp_ram_ctrl_if.sv
// Producer/consumer handshake bundle for fifo_sp_ram_ctrl.
// master = producer/consumer side, slave = the FIFO controller.
interface fifo_sp_ram_ctrl_if #(
    parameter int G_DATA_WIDTH = 8
);
    logic                    wr_en;
    logic                    rd_en;
    logic [G_DATA_WIDTH-1:0] wdata;
    logic [G_DATA_WIDTH-1:0] rdata;
    logic                    rdata_val;
    logic                    fifo_empty;
    logic                    fifo_full;

    modport master (
        output wr_en, rd_en, wdata,
        input  rdata, rdata_val, fifo_empty, fifo_full
    );

    modport slave (
        input  wr_en, rd_en, wdata,
        output rdata, rdata_val, fifo_empty, fifo_full
    );
endinterface

// File: rtl/fifo_sp_ram_ctrl.sv
// Synchronous FIFO controller driving an external RAM with a 1-cycle registered read.
// Optional sticky overflow/underflow outputs when FIFO_SP_RAM_CTRL_ERR_FLAGS_EN is defined.
module fifo_sp_ram_ctrl #(
    parameter int G_DATA_WIDTH = 8,
    parameter int G_ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fifo_sp_ram_ctrl_if.slave       bus,
    output logic [G_DATA_WIDTH-1:0] wdata_out,
    output logic                    we,
    output logic [G_ADDR_WIDTH-1:0] wr_addr,
    output logic [G_ADDR_WIDTH-1:0] rd_addr,
`ifdef FIFO_SP_RAM_CTRL_ERR_FLAGS_EN
    output logic                    overflow,
    output logic                    underflow,
`endif
    input  logic [G_DATA_WIDTH-1:0] rdata_in
);

    localparam logic [G_ADDR_WIDTH:0]   C_CNT_ZERO = {(G_ADDR_WIDTH+1){1'b0}};
    localparam logic [G_ADDR_WIDTH:0]   C_CNT_ONE  = {{G_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [G_ADDR_WIDTH:0]   C_CNT_FULL = {1'b1, {G_ADDR_WIDTH{1'b0}}};
    localparam logic [G_ADDR_WIDTH-1:0] C_PTR_ZERO = {G_ADDR_WIDTH{1'b0}};
    localparam logic [G_ADDR_WIDTH-1:0] C_PTR_ONE  = {{(G_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [G_DATA_WIDTH-1:0] C_DAT_ZERO = {G_DATA_WIDTH{1'b0}};

    logic [G_ADDR_WIDTH-1:0] wr_ptr_r;
    logic [G_ADDR_WIDTH-1:0] rd_ptr_r;
    logic [G_ADDR_WIDTH:0]   count_r;
    logic [G_ADDR_WIDTH:0]   count_next_s;
    logic                    fifo_empty_r;
    logic                    fifo_full_r;
    logic                    pop_d_r;
    logic                    rdata_val_r;
    logic [G_DATA_WIDTH-1:0] rdata_r;
    logic                    push_ok_s;
    logic                    pop_ok_s;

    // Requests are gated by the registered flags only, never by the opposite request.
    assign push_ok_s = bus.wr_en & ~fifo_full_r;
    assign pop_ok_s  = bus.rd_en & ~fifo_empty_r;

    assign we        = push_ok_s;
    assign wdata_out = bus.wdata;
    assign wr_addr   = wr_ptr_r;
    assign rd_addr   = rd_ptr_r;

    assign bus.rdata      = rdata_r;
    assign bus.rdata_val  = rdata_val_r;
    assign bus.fifo_empty = fifo_empty_r;
    assign bus.fifo_full  = fifo_full_r;

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + C_CNT_ONE;
            2'b01:   count_next_s = count_r - C_CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r     <= C_PTR_ZERO;
            rd_ptr_r     <= C_PTR_ZERO;
            count_r      <= C_CNT_ZERO;
            fifo_empty_r <= 1'b1;
            fifo_full_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + C_PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + C_PTR_ONE;
            end
            count_r      <= count_next_s;
            fifo_empty_r <= (count_next_s == C_CNT_ZERO);
            fifo_full_r  <= (count_next_s == C_CNT_FULL);
        end
    end

    // The RAM registers the word on the pop edge, so it is captured one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_d_r     <= 1'b0;
            rdata_val_r <= 1'b0;
            rdata_r     <= C_DAT_ZERO;
        end else begin
            pop_d_r     <= pop_ok_s;
            rdata_val_r <= pop_d_r;
            if (pop_d_r) begin
                rdata_r <= rdata_in;
            end
        end
    end

`ifdef FIFO_SP_RAM_CTRL_ERR_FLAGS_EN
    logic overflow_r;
    logic underflow_r;

    assign overflow  = overflow_r;
    assign underflow = underflow_r;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (bus.wr_en && fifo_full_r) begin
                overflow_r <= 1'b1;
            end
            if (bus.rd_en && fifo_empty_r) begin
                underflow_r <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sp_ram_ctrl.sv
// Scoreboard bench for fifo_sp_ram_ctrl with a behavioural 1-cycle-latency RAM.
// Honours FIFO_SP_RAM_CTRL_ERR_FLAGS_EN for the optional error outputs.
module tb_fifo_sp_ram_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] wdata_out;
    logic          we;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rdata_in;
`ifdef FIFO_SP_RAM_CTRL_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    fifo_sp_ram_ctrl_if #(.G_DATA_WIDTH(DW)) bus ();

    fifo_sp_ram_ctrl #(.G_DATA_WIDTH(DW), .G_ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .wdata_out (wdata_out),
        .we        (we),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
`ifdef FIFO_SP_RAM_CTRL_ERR_FLAGS_EN
        .overflow  (overflow),
        .underflow (underflow),
`endif
        .rdata_in  (rdata_in)
    );

    logic [DW-1:0] mem [0:DEPTH-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: write on we, register mem[rd_addr] every clock.
    always @(posedge clk) begin
        if (we) mem[wr_addr] <= wdata_out;
        rdata_in <= mem[rd_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [DW-1:0] m_fifo [$];
    logic [DW-1:0] exp_q  [$];
    logic [AW-1:0] m_wp, m_rp;
    int            m_count;
    logic          m_pop_d, m_val;
    logic [DW-1:0] m_rdata;
    logic          m_ovf, m_unf;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_wp = '0; m_rp = '0; m_count = 0;
        m_pop_d = 1'b0; m_val = 1'b0; m_rdata = '0;
        m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic check_regs();
        check("rdata_val", 32'(bus.rdata_val), 32'(m_val));
        check("rdata", 32'(bus.rdata), 32'(m_rdata));
        check("fifo_empty", 32'(bus.fifo_empty), 32'(m_count == 0));
        check("fifo_full", 32'(bus.fifo_full), 32'(m_count == DEPTH));
`ifdef FIFO_SP_RAM_CTRL_ERR_FLAGS_EN
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
`endif
    endtask

    // One clock of stimulus: drive, check combinational RAM side, advance model, check registers.
    task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d);
        logic push, pop;
        bus.wr_en = wr;
        bus.rd_en = rd;
        bus.wdata = d;
        #1;
        push = wr && (m_count != DEPTH);
        pop  = rd && (m_count != 0);
        check("we", 32'(we), 32'(push));
        check("wr_addr", 32'(wr_addr), 32'(m_wp));
        check("rd_addr", 32'(rd_addr), 32'(m_rp));
        if (push) check("wdata_out", 32'(wdata_out), 32'(d));
        if (wr && m_count == DEPTH) m_ovf = 1'b1;
        if (rd && m_count == 0) m_unf = 1'b1;
        if (pop) begin
            exp_q.push_back(m_fifo.pop_front());
            m_rp = m_rp + 1'b1;
        end
        if (push) begin
            m_fifo.push_back(d);
            m_wp = m_wp + 1'b1;
        end
        m_count = m_count + (push ? 1 : 0) - (pop ? 1 : 0);
        m_val   = m_pop_d;
        m_pop_d = pop;
        @(posedge clk);
        #1;
        if (m_val) begin
            if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
            else m_rdata = exp_q.pop_front();
        end
        check_regs();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        rst_n = 1'b1;

        // Basic three-word push/pop
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h33);
        repeat (3) step(1'b0, 1'b1, 8'h00);
        repeat (3) step(1'b0, 1'b0, 8'h00);

        // Read while empty: no pulse, pointer and rdata held
        repeat (3) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Fill to full, one rejected write, drain completely
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 8'hAA);
        step(1'b1, 1'b1, 8'hAB);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, 8'h00);
        repeat (3) step(1'b0, 1'b0, 8'h00);

        // Streaming with one word resident
        step(1'b1, 1'b0, 8'h01);
        for (int i = 2; i < 40; i++) step(1'b1, 1'b1, 8'(i));
        step(1'b0, 1'b1, 8'h00);
        repeat (3) step(1'b0, 1'b0, 8'h00);

        // Interleaved traffic across the pointer wrap; error flags must not move here
        model_reset_err();
        for (int i = 0; i < 1500; i++) begin
            step(1'b1, 1'b0, 8'($urandom));
            step(1'b0, 1'b1, 8'h00);
        end
        repeat (3) step(1'b0, 1'b0, 8'h00);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
        step(1'b0, 1'b1, 8'h00);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        check("rst_mid_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_mid_rd_addr", 32'(rd_addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h5A);
        step(1'b0, 1'b1, 8'h00);
        repeat (3) step(1'b0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Sticky flags may legitimately be set by earlier tests; a reset clears them for the wrap run.
    task automatic model_reset_err();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_regs();
    endtask

endmodule
